// File: rtl/obs_pkg.sv
// Shared types and sizing helpers for the parametrised OBS overlap combiner.
package obs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } obs_ovl_state_t;

  // Number of BUSY cycles needed to sweep W input positions CH at a time.
  function automatic int obs_nchunk(input int w, input int ch);
    return (w + ch - 1) / ch;
  endfunction

  // Width of the combined polynomial.
  function automatic int obs_out_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/obs_overlap_slice.sv
// One chunk of the overlap combiner: interleaves CH input positions into 2*CH
// output bits. Lanes at or beyond position W are forced to zero so a partial
// final chunk cannot disturb bits above the polynomial.
module obs_overlap_slice
  import obs_pkg::*;
#(
  parameter int W  = 97,
  parameter int CH = 16,
  parameter int BW = 7
) (
  input  logic [BW-1:0]   base,
  input  logic [CH-1:0]   s1,
  input  logic [CH-1:0]   s2,
  input  logic [CH-1:0]   s3,
  input  logic [CH-1:0]   s4,
  input  logic            cin,
  output logic [2*CH-1:0] chunk,
  output logic [CH-1:0]   lane_vld,
  output logic            cout
);

  // Even bits take s1 plus the s4 bit one position down; odd bits take s2^s3.
  always_comb begin
    chunk    = '0;
    lane_vld = '0;
    for (int j = 0; j < CH; j++) begin
      lane_vld[j]    = (int'(base) + j) < W;
      chunk[2*j+1]   = lane_vld[j] & (s2[j] ^ s3[j]);
    end
    chunk[0] = lane_vld[0] & (s1[0] ^ cin);
    for (int j = 1; j < CH; j++) begin
      chunk[2*j] = lane_vld[j] & (s1[j] ^ s4[j-1]);
    end
  end

  // Top s4 bit of this chunk is the carry-in of the next chunk.
  assign cout = s4[CH-1];

endmodule

// File: rtl/obs_overlap_seq.sv
// Handshaked, chunked OBS overlap combiner. Captures four GF(2) sub-products,
// then folds CH positions per cycle into the held (2W+1)-bit result, either
// replacing or XOR-accumulating into the previous result.
module obs_overlap_seq
  import obs_pkg::*;
#(
  parameter int W  = 97,
  parameter int CH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_acc,
  input  logic [W-1:0] b_in1,
  input  logic [W-1:0] b_in2,
  input  logic [W-1:0] b_in3,
  input  logic [W-1:0] b_in4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2*W:0] out_data,
  output logic         busy
);

  localparam int NCHUNK = obs_nchunk(W, CH);
  localparam int OW     = obs_out_w(W);
  localparam int PADW   = NCHUNK * CH;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (PADW > 1) ? $clog2(PADW) : 1;
  localparam int OIW    = $clog2(OW);

  obs_ovl_state_t r_state;
  logic [KW-1:0]  r_k;
  logic [OW-1:0]  r_out;
  logic [W-1:0]   r_b1, r_b2, r_b3, r_b4;
  logic           r_carry;

  logic            w_accept;
  logic            w_last;
  logic [BW-1:0]   w_base;
  logic [PADW-1:0] w_b1p, w_b2p, w_b3p, w_b4p;
  logic [2*CH-1:0] w_chunk;
  logic [CH-1:0]   w_lane_vld;
  logic            w_cout;
  logic [OW-1:0]   w_upd;
  logic [OIW-1:0]  w_idx;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign busy      = (r_state == BUSY);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_out;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_k == KW'(NCHUNK - 1));
  assign w_base    = BW'(int'(r_k) * CH);

  // Zero-padding lets every chunk use a full-width part select.
  assign w_b1p = PADW'(r_b1);
  assign w_b2p = PADW'(r_b2);
  assign w_b3p = PADW'(r_b3);
  assign w_b4p = PADW'(r_b4);

  obs_overlap_slice #(
    .W  (W),
    .CH (CH),
    .BW (BW)
  ) u_slice (
    .base     (w_base),
    .s1       (w_b1p[w_base +: CH]),
    .s2       (w_b2p[w_base +: CH]),
    .s3       (w_b3p[w_base +: CH]),
    .s4       (w_b4p[w_base +: CH]),
    .cin      (r_carry),
    .chunk    (w_chunk),
    .lane_vld (w_lane_vld),
    .cout     (w_cout)
  );

  // Scatter the chunk to its output position; the last chunk also owns out[2W].
  always_comb begin
    w_upd = '0;
    w_idx = '0;
    for (int j = 0; j < CH; j++) begin
      if (w_lane_vld[j]) begin
        w_idx                  = OIW'(2 * (int'(w_base) + j));
        w_upd[w_idx]           = w_chunk[2*j];
        w_upd[w_idx | OIW'(1)] = w_chunk[2*j+1];
      end
    end
    if (w_last) w_upd[OW-1] = r_b4[W-1];
  end

  // Control FSM, operand capture and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_out   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_b1    <= b_in1;
      r_b2    <= b_in2;
      r_b3    <= b_in3;
      r_b4    <= b_in4;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_state <= BUSY;
      if (!in_acc) r_out <= '0;
    end else begin
      case (r_state)
        BUSY: begin
          r_out   <= r_out ^ w_upd;
          r_carry <= w_cout;
          if (w_last) begin
            r_k     <= '0;
            r_state <= DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        IDLE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obs_overlap_seq.sv
// Directed bench for obs_overlap_seq. Four instances (CH = 16, 1, 7, 97) share
// the stimulus; the CH=16 instance carries the directed scenarios and all four
// are compared against an independent reference in the sweep.
module tb_obs_overlap_seq;

  localparam int W  = 97;
  localparam int OW = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_acc;
  logic          out_ready;
  logic [W-1:0]  b1, b2, b3, b4;
  logic          in_ready  [4];
  logic          out_valid [4];
  logic          busy      [4];
  logic [OW-1:0] out_data  [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  obs_overlap_seq #(.W(W), .CH(16)) u_ch16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_acc(in_acc),
    .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]), .busy(busy[0]));

  obs_overlap_seq #(.W(W), .CH(1)) u_ch1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_acc(in_acc),
    .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]), .busy(busy[1]));

  obs_overlap_seq #(.W(W), .CH(7)) u_ch7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_acc(in_acc),
    .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]), .busy(busy[2]));

  obs_overlap_seq #(.W(W), .CH(97)) u_ch97 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]), .in_acc(in_acc),
    .b_in1(b1), .b_in2(b2), .b_in3(b3), .b_in4(b4),
    .out_valid(out_valid[3]), .out_ready(out_ready), .out_data(out_data[3]), .busy(busy[3]));

  function automatic int nch(input int j);
    case (j)
      0:       return 7;
      1:       return 97;
      2:       return 14;
      default: return 1;
    endcase
  endfunction

  // Reference combiner written straight from the bit equations.
  function automatic logic [OW-1:0] model(input logic [W-1:0] a1, a2, a3, a4);
    logic [OW-1:0] r;
    logic          e;
    r = '0;
    for (int i = 0; i <= W; i++) begin
      e = 1'b0;
      if (i < W) e = e ^ a1[i];
      if (i > 0) e = e ^ a4[i-1];
      r[2*i] = e;
      if (i < W) r[2*i+1] = a2[i] ^ a3[i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge
  // with the operand buses scrambled, so held inputs cannot leak into the result.
  task automatic send(input logic [W-1:0] a1, a2, a3, a4, input logic acc);
    b1 = a1; b2 = a2; b3 = a3; b4 = a4;
    in_acc   = acc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_acc   = 1'($urandom);
    b1 = rnd(); b2 = rnd(); b3 = rnd(); b4 = rnd();
  endtask

  // Counts rising edges until the CH=16 instance raises out_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (out_valid[0] !== 1'b1) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
    b1 = '0; b2 = '0; b3 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (out_valid[j] !== 1'b0 || busy[j] !== 1'b0 || in_ready[j] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got valid=%b busy=%b ready=%b, expected 0 0 1",
                 j, out_valid[j], busy[j], in_ready[j]);
      end
      n_checks++;
      if (out_data[j] !== '0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got %h expected 0", j, out_data[j]);
      end
    end
  endtask

  task automatic test_even_bits();
    int lat;
    logic [OW-1:0] exp_v;
    exp_v = {2'b00, {96{2'b10}}, 1'b1};
    send('1, '0, '0, '0, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (lat !== 7) begin
      n_fail++;
      $display("FAIL even_latency: got %0d expected 7", lat);
    end
    n_checks++;
    if (out_data[0] !== exp_v) begin
      n_fail++;
      $display("FAIL even_bits: got %h expected %h", out_data[0], exp_v);
    end
    release_out();
  endtask

  task automatic test_b4_edges();
    int lat;
    send('0, '0, '0, W'(1) << 96, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== (OW'(1) << 194) || lat !== 7) begin
      n_fail++;
      $display("FAIL b4_top: got %h lat %0d expected %h lat 7", out_data[0], lat, OW'(1) << 194);
    end
    release_out();
    send('0, '0, '0, W'(1), 1'b0);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== OW'(4) || lat !== 7) begin
      n_fail++;
      $display("FAIL b4_low: got %h lat %0d expected 4 lat 7", out_data[0], lat);
    end
    release_out();
  endtask

  task automatic test_odd_bits();
    int lat;
    send('0, '1, '1, '0, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== '0 || lat !== 7) begin
      n_fail++;
      $display("FAIL odd_cancel: got %h lat %0d expected 0 lat 7", out_data[0], lat);
    end
    release_out();
    send('0, W'(1) << 96, '0, '0, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== (OW'(1) << 193) || lat !== 7) begin
      n_fail++;
      $display("FAIL odd_top: got %h lat %0d expected %h", out_data[0], lat, OW'(1) << 193);
    end
    release_out();
  endtask

  task automatic test_accumulate();
    int lat;
    logic [OW-1:0] exp_c;
    exp_c = (OW'(1) << 194) | OW'(2);
    send(W'(1), '0, '0, '0, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== OW'(1)) begin
      n_fail++;
      $display("FAIL acc_a: got %h expected 1", out_data[0]);
    end
    release_out();
    send(W'(1), W'(1), '0, '0, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== OW'(2)) begin
      n_fail++;
      $display("FAIL acc_b: got %h expected 2", out_data[0]);
    end
    release_out();
    send('0, '0, '0, W'(1) << 96, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== exp_c) begin
      n_fail++;
      $display("FAIL acc_top_set: got %h expected %h", out_data[0], exp_c);
    end
    release_out();
    send('0, '0, '0, W'(1) << 96, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (out_data[0] !== OW'(2)) begin
      n_fail++;
      $display("FAIL acc_top_clear: got %h expected 2", out_data[0]);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] a1, a2, a3, a4, c1, c2, c3, c4;
    logic [OW-1:0] exp1, exp2;
    a1 = rnd(); a2 = rnd(); a3 = rnd(); a4 = rnd();
    c1 = rnd(); c2 = rnd(); c3 = rnd(); c4 = rnd();
    exp1 = model(a1, a2, a3, a4);
    exp2 = model(c1, c2, c3, c4);
    send(a1, a2, a3, a4, 1'b0);
    wait_valid(lat);
    for (int n = 0; n < 5; n++) begin
      n_checks++;
      if (out_data[0] !== exp1 || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got data %h ready %b valid %b expected %h 0 1",
                 n, out_data[0], in_ready[0], out_valid[0], exp1);
      end
      @(negedge clk);
    end
    b1 = c1; b2 = c2; b3 = c3; b4 = c4;
    in_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ready_follow: got %b expected 1", in_ready[0]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    b1 = rnd(); b2 = rnd(); b3 = rnd(); b4 = rnd();
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reaccept: got valid %b busy %b expected 0 1", out_valid[0], busy[0]);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 7 || out_data[0] !== exp2) begin
      n_fail++;
      $display("FAIL b2b_result: got %h lat %0d expected %h lat 7", out_data[0], lat, exp2);
    end
    release_out();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [W-1:0] a1, a2, a3, a4;
    logic [OW-1:0] exp_v;
    send(rnd(), rnd(), rnd(), rnd(), 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_data[0] !== '0) begin
      n_fail++;
      $display("FAIL midbusy_reset: got valid %b busy %b ready %b data %h expected 0 0 1 0",
               out_valid[0], busy[0], in_ready[0], out_data[0]);
    end
    a1 = rnd(); a2 = rnd(); a3 = rnd(); a4 = rnd();
    exp_v = model(a1, a2, a3, a4);
    send(a1, a2, a3, a4, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (lat !== 7 || out_data[0] !== exp_v) begin
      n_fail++;
      $display("FAIL after_reset_op: got %h lat %0d expected %h lat 7", out_data[0], lat, exp_v);
    end
    release_out();
  endtask

  task automatic test_sweep();
    int first [4];
    int cyc;
    logic [W-1:0] a1, a2, a3, a4;
    logic [OW-1:0] prev, exp_v;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev = '0;
    for (int it = 0; it < 4; it++) begin
      a1 = rnd(); a2 = rnd(); a3 = rnd(); a4 = rnd();
      exp_v = (it == 2) ? (prev ^ model(a1, a2, a3, a4)) : model(a1, a2, a3, a4);
      send(a1, a2, a3, a4, (it == 2));
      for (int j = 0; j < 4; j++) first[j] = -1;
      cyc = 0;
      while (first[1] < 0 && cyc < 150) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int j = 0; j < 4; j++)
          if (first[j] < 0 && out_valid[j] === 1'b1) first[j] = cyc;
      end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (first[j] !== nch(j) || out_data[j] !== exp_v) begin
          n_fail++;
          $display("FAIL sweep_it%0d_inst%0d: got lat %0d data %h expected lat %0d data %h",
                   it, j, first[j], out_data[j], nch(j), exp_v);
        end
      end
      release_out();
      prev = exp_v;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_even_bits();
    test_b4_edges();
    test_odd_bits();
    test_accumulate();
    test_back_to_back();
    test_reset_mid_busy();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obs_overlap_seq.md
Name: obs_overlap_seq

Overview:
- Parametrised, handshaked successor to the fixed-width OBS overlap combiner.
- Merges four GF(2) sub-products of width W into one (2W+1)-bit polynomial by interleaving them with XOR.
- Processes CH bit-positions per cycle, so one instance serves any OBS level.
- Optional accumulate mode XORs the new result into the held result; this lets a single instance fold several levels of a multiplication tree.

Parameters:
- W, 97, width of each sub-product input; output width is 2W+1.
- CH, 16, input bit-positions processed per cycle; 1 <= CH <= W.
- NCHUNK, derived as ceil(W/CH), number of BUSY cycles per operation (localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands this cycle.
- in_acc  in  1  sampled on accept; 1 = XOR the result into the current out_data instead of replacing it.
- b_in1  in  W  sub-product 1 (drives even output bits).
- b_in2  in  W  sub-product 2 (drives odd output bits).
- b_in3  in  W  sub-product 3 (drives odd output bits).
- b_in4  in  W  sub-product 4 (drives even output bits, shifted up one position).
- out_valid  out  1  out_data is complete and held.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  2W+1  combined polynomial.
- busy  out  1  high while in the BUSY state.

Behaviour:
- Reset is synchronous and active-high; there is one clock, clk. While rst is high at an edge:
  - state goes to IDLE and the chunk counter to 0;
  - out_data, out_valid and busy go to 0, and in_ready reads 1 after the edge;
  - any in-flight operation is dropped silently.
- Function, for i = 0..W, treating out-of-range input bits as 0:
  - out[2i] = b_in1[i] ^ b_in4[i-1];
  - out[2i+1] = b_in2[i] ^ b_in3[i] for i < W.
  - Endpoints: out[0] = b_in1[0] and out[2W] = b_in4[W-1].
- States:
  - IDLE: in_ready = 1.
  - BUSY: busy = 1, in_ready = 0.
  - DONE: out_valid = 1, in_ready = out_ready.
- Accept happens on the edge where in_valid & in_ready. At that edge:
  - capture b_in1..4 and in_acc;
  - if in_acc = 0, clear out_data;
  - set chunk counter k = 0 and go to BUSY.
- BUSY, chunk k: XOR into out_data the even and odd bits for i in [k*CH, min(k*CH+CH, W)).
  - The final chunk additionally writes out[2W]; this bit is also XOR-accumulated.
  - After chunk NCHUNK-1, go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
  - Example: W=97, CH=16 gives 7 cycles; CH=W gives 1 cycle.
- DONE:
  - out_data is stable until the handshake.
  - out_valid & out_ready with in_valid = 0: go to IDLE; out_data is retained, so in_acc can chain on it.
  - out_valid & out_ready & in_valid in the same cycle: this is a simultaneous accept; go directly to BUSY. Sustained throughput is one result per NCHUNK+1 cycles.
- in_acc with out_data = 0, for example after reset, behaves as replace.
- Partial final chunk: when W mod CH != 0, the out-of-range lanes must be masked. They must never write out_data bits above 2W.
- Counter width is max(1, clog2(NCHUNK)). The counter wraps only via the state transition, never past NCHUNK-1.
- Inputs are ignored outside the accept edge; changing b_in* during BUSY has no effect.
- No combinational path from in_valid or out_ready to out_data; out_ready reaches in_ready combinationally only in DONE.

Decomposition:
- Package obs_pkg holds:
  - state enum obs_ovl_state_t (IDLE, BUSY, DONE);
  - function obs_nchunk(W, CH);
  - constant function obs_out_w(W) = 2W+1.
- Sub-module obs_overlap_slice (purely combinational):
  - inputs: CH-wide slices of b_in1..b_in4, plus b_in4 bit k*CH-1 as carry-in;
  - outputs: a 2CH-bit interleaved chunk and a lane-valid mask.
  - The parent positions the chunk at bit 2*k*CH and handles out[2W].

Test Plan:
- W=97, CH=16. b_in1 = all ones, others 0 → out_valid at accept+7; out_data even bits 0..192 = 1; odd bits and bit 194 = 0.
- b_in4 = 1<<96 only → out_data = 1<<194. Then b_in4 = 1 only → out_data = 1<<2.
- b_in2 = b_in3 = all ones → out_data = 0. Then b_in2 = 1<<96 only → out_data = 1<<193.
- Accumulate:
  - op A: b_in1 = 1, in_acc = 0 → out_data = 0x1;
  - op B: b_in1 = 1, b_in2 = 1, in_acc = 1 → out_data = 0x2.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE → out_data stable and in_ready = 0. Then assert out_ready and in_valid in the same cycle → new op accepted; out_valid drops for 7 cycles and returns with the new result.
- Reset and sweep:
  - assert rst during BUSY at k = 3 → next cycle out_valid = 0, busy = 0, in_ready = 1, out_data = 0; a following op produces the correct result;
  - repeat the random-vs-model comparison with CH=1, 7, 97 (NCHUNK = 97, 14, 1).
